// File: rtl/ghost_nav_ctrl.sv
// ghost_nav_ctrl: per-ghost navigation controller.
// Runs the SCATTER/CHASE/FRIGHT mode schedule and a 16-bit LFSR for
// frightened wandering. Each decision request goes through two stages:
// stage 1 registers the neighbour distances, stage 2 picks a direction.
`timescale 1ns/1ps
module ghost_nav_ctrl #(
  parameter int          COORD_W       = 8,
  parameter int          SCATTER_TICKS = 420,
  parameter int          CHASE_TICKS   = 1200,
  parameter int          FRIGHT_TICKS  = 360,
  parameter int          NEAR_DIST     = 64,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   tick_en,
  input  logic                   step,
  input  logic                   fright_start,
  input  logic [2*COORD_W-1:0]   cur_loc,
  input  logic [2*COORD_W-1:0]   pac_loc,
  input  logic [2*COORD_W-1:0]   corner_loc,
  input  logic                   clear_left,
  input  logic                   clear_right,
  input  logic                   clear_up,
  input  logic                   clear_down,
  output logic [2*COORD_W-1:0]   direction,
  output logic                   dir_valid,
  output logic                   busy,
  output logic [1:0]             mode
);

  localparam int LW   = 2 * COORD_W;
  localparam int DW   = 2 * COORD_W + 1;
  localparam int TMAX = (SCATTER_TICKS > CHASE_TICKS) ? SCATTER_TICKS : CHASE_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int FW   = $clog2(FRIGHT_TICKS + 1);

  localparam logic [15:0]   SEED         = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [TW-1:0] SCATTER_LAST = TW'(SCATTER_TICKS - 1);
  localparam logic [TW-1:0] CHASE_LAST   = TW'(CHASE_TICKS - 1);
  localparam logic [FW-1:0] FRIGHT_LOAD  = FW'(FRIGHT_TICKS);
  localparam logic [DW-1:0] NEAR_LIMIT   = DW'(NEAR_DIST);

  localparam logic [1:0] MODE_SCATTER = 2'd0;
  localparam logic [1:0] MODE_CHASE   = 2'd1;
  localparam logic [1:0] MODE_FRIGHT  = 2'd2;

  // Direction indices double as tie-break priority; reverse is index ^ 2.
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  function automatic logic [LW-1:0] dir_delta(input logic [1:0] d);
    logic [LW-1:0] v;
    case (d)
      DIR_UP:   v = {{COORD_W{1'b0}}, {COORD_W{1'b1}}};
      DIR_LEFT: v = {COORD_W'(1), {COORD_W{1'b0}}};
      DIR_DOWN: v = {{COORD_W{1'b0}}, COORD_W'(1)};
      default:  v = {{COORD_W{1'b1}}, {COORD_W{1'b0}}};
    endcase
    return v;
  endfunction

  function automatic logic [LW-1:0] loc_add(input logic [LW-1:0] a, input logic [LW-1:0] d);
    logic [COORD_W-1:0] c;
    logic [COORD_W-1:0] r;
    c = a[LW-1:COORD_W] + d[LW-1:COORD_W];
    r = a[COORD_W-1:0] + d[COORD_W-1:0];
    return {c, r};
  endfunction

  function automatic logic [DW-1:0] sq_dist(input logic [LW-1:0] a, input logic [LW-1:0] b);
    logic [COORD_W-1:0] dc;
    logic [COORD_W-1:0] dr;
    logic [LW-1:0]      pc;
    logic [LW-1:0]      pr;
    dc = (a[LW-1:COORD_W] >= b[LW-1:COORD_W]) ? a[LW-1:COORD_W] - b[LW-1:COORD_W]
                                              : b[LW-1:COORD_W] - a[LW-1:COORD_W];
    dr = (a[COORD_W-1:0] >= b[COORD_W-1:0]) ? a[COORD_W-1:0] - b[COORD_W-1:0]
                                            : b[COORD_W-1:0] - a[COORD_W-1:0];
    pc = {{COORD_W{1'b0}}, dc} * {{COORD_W{1'b0}}, dc};
    pr = {{COORD_W{1'b0}}, dr} * {{COORD_W{1'b0}}, dr};
    return {1'b0, pc} + {1'b0, pr};
  endfunction

  logic [15:0]   lfsr;
  logic [TW-1:0] mode_timer;
  logic [TW-1:0] saved_timer;
  logic [1:0]    saved_mode;
  logic [FW-1:0] fright_cnt;
  logic          reverse_pending;
  logic          rp_set;
  logic [1:0]    last_dir;

  logic [3:0]    clear_vec;
  logic          near_pac;
  logic [LW-1:0] target;
  logic [DW-1:0] nb_dist [4];

  logic [1:0]    cap_mode;
  logic          cap_rp;
  logic [1:0]    cap_last;
  logic [1:0]    cap_rnd;
  logic [3:0]    cap_clear;
  logic [DW-1:0] cap_dist [4];

  logic [1:0]    rev_dir;
  logic [3:0]    allowed;
  logic [1:0]    pick;
  logic          pick_ok;
  logic [DW-1:0] best_dist;
  logic [1:0]    scan_idx;

  assign clear_vec = {clear_right, clear_down, clear_left, clear_up};

  // Free-running Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // A reverse is requested on every schedule flip and on entry into FRIGHT.
  always_comb begin
    rp_set = 1'b0;
    if (fright_start) begin
      rp_set = (mode != MODE_FRIGHT);
    end else if (tick_en) begin
      if ((mode == MODE_SCATTER) && (mode_timer == SCATTER_LAST)) begin
        rp_set = 1'b1;
      end
      if ((mode == MODE_CHASE) && (mode_timer == CHASE_LAST)) begin
        rp_set = 1'b1;
      end
    end
  end

  // Mode schedule; fright_start has priority and swallows a same-edge tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode        <= MODE_SCATTER;
      mode_timer  <= '0;
      saved_mode  <= MODE_SCATTER;
      saved_timer <= '0;
      fright_cnt  <= '0;
    end else if (fright_start) begin
      if (mode != MODE_FRIGHT) begin
        saved_mode  <= mode;
        saved_timer <= mode_timer;
        mode        <= MODE_FRIGHT;
      end
      fright_cnt <= FRIGHT_LOAD;
    end else if (tick_en) begin
      case (mode)
        MODE_SCATTER: begin
          if (mode_timer == SCATTER_LAST) begin
            mode       <= MODE_CHASE;
            mode_timer <= '0;
          end else begin
            mode_timer <= mode_timer + 1'b1;
          end
        end
        MODE_CHASE: begin
          if (mode_timer == CHASE_LAST) begin
            mode       <= MODE_SCATTER;
            mode_timer <= '0;
          end else begin
            mode_timer <= mode_timer + 1'b1;
          end
        end
        MODE_FRIGHT: begin
          if (fright_cnt <= FW'(1)) begin
            mode       <= saved_mode;
            mode_timer <= saved_timer;
          end else begin
            fright_cnt <= fright_cnt - 1'b1;
          end
        end
        default: mode <= MODE_SCATTER;
      endcase
    end
  end

  // Reverse request: a new request beats the clear from a consuming decision.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reverse_pending <= 1'b0;
    end else if (rp_set) begin
      reverse_pending <= 1'b1;
    end else if (busy && cap_rp) begin
      reverse_pending <= 1'b0;
    end
  end

  // Stage 1 combinational: target choice and distances of the four neighbours.
  always_comb begin
    near_pac = (sq_dist(cur_loc, pac_loc) < NEAR_LIMIT);
    target   = ((mode == MODE_CHASE) && !near_pac) ? pac_loc : corner_loc;
    for (int i = 0; i < 4; i++) begin
      nb_dist[i] = clear_vec[i] ? sq_dist(loc_add(cur_loc, dir_delta(2'(i))), target)
                                : {DW{1'b1}};
    end
  end

  // Stage 2 combinational: forced reverse, random wander, or shortest distance.
  always_comb begin
    rev_dir   = cap_last ^ 2'b10;
    allowed   = cap_clear & ~(4'b0001 << rev_dir);
    if (allowed == 4'b0000) begin
      allowed = cap_clear & (4'b0001 << rev_dir);
    end
    pick      = DIR_UP;
    pick_ok   = 1'b0;
    best_dist = {DW{1'b1}};
    scan_idx  = 2'd0;
    if (cap_rp && cap_clear[rev_dir]) begin
      pick    = rev_dir;
      pick_ok = 1'b1;
    end else if (cap_mode == MODE_FRIGHT) begin
      for (int k = 0; k < 4; k++) begin
        scan_idx = cap_rnd + 2'(k);
        if (!pick_ok && allowed[scan_idx]) begin
          pick    = scan_idx;
          pick_ok = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (allowed[k] && (!pick_ok || (cap_dist[k] < best_dist))) begin
          pick      = 2'(k);
          best_dist = cap_dist[k];
          pick_ok   = 1'b1;
        end
      end
    end
  end

  // Decision pipeline: capture on an idle step, resolve on the following edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      dir_valid <= 1'b0;
      direction <= '0;
      last_dir  <= DIR_LEFT;
      cap_mode  <= MODE_SCATTER;
      cap_rp    <= 1'b0;
      cap_last  <= DIR_LEFT;
      cap_rnd   <= 2'd0;
      cap_clear <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        cap_dist[i] <= '0;
      end
    end else begin
      dir_valid <= 1'b0;
      if (busy) begin
        busy      <= 1'b0;
        dir_valid <= 1'b1;
        direction <= pick_ok ? dir_delta(pick) : '0;
        if (pick_ok) begin
          last_dir <= pick;
        end
      end else if (step) begin
        busy      <= 1'b1;
        cap_mode  <= mode;
        cap_rp    <= reverse_pending;
        cap_last  <= last_dir;
        cap_rnd   <= lfsr[1:0];
        cap_clear <= clear_vec;
        for (int i = 0; i < 4; i++) begin
          cap_dist[i] <= nb_dist[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_ghost_nav_ctrl.sv
// tb_ghost_nav_ctrl: directed and randomized bench for ghost_nav_ctrl,
// checked cycle by cycle against a behavioural model of the controller.
`timescale 1ns/1ps
module tb_ghost_nav_ctrl;

  localparam int SCAT = 3;
  localparam int CHAS = 5;
  localparam int FRIG = 4;
  localparam int NEAR = 64;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clock;
  logic        reset;
  logic        tick_en;
  logic        step;
  logic        fright_start;
  logic [15:0] cur_loc;
  logic [15:0] pac_loc;
  logic [15:0] corner_loc;
  logic [3:0]  clr;
  logic [15:0] direction;
  logic        dir_valid;
  logic        busy;
  logic [1:0]  mode;

  int checkCount = 0;
  int errorCount = 0;

  // Neighbour offsets by index: UP, LEFT, DOWN, RIGHT.
  int dcol [4] = '{0, 1, 0, -1};
  int drow [4] = '{-1, 0, 1, 0};

  // Model state, written only by the main stimulus process.
  int          m_mode;
  int          m_timer;
  int          m_saved_mode;
  int          m_saved_timer;
  int          m_fleft;
  int          m_last;
  int          m_pend;
  bit          m_rp;
  bit          m_busy;
  bit          m_pend_rp;
  bit          m_dv;
  logic [15:0] m_lfsr;
  logic [15:0] m_dir_out;

  ghost_nav_ctrl #(
    .COORD_W(8), .SCATTER_TICKS(SCAT), .CHASE_TICKS(CHAS),
    .FRIGHT_TICKS(FRIG), .NEAR_DIST(NEAR), .LFSR_SEED(SEED)
  ) dut (
    .clock(clock), .reset(reset), .tick_en(tick_en), .step(step),
    .fright_start(fright_start), .cur_loc(cur_loc), .pac_loc(pac_loc),
    .corner_loc(corner_loc), .clear_left(clr[1]), .clear_right(clr[3]),
    .clear_up(clr[0]), .clear_down(clr[2]), .direction(direction),
    .dir_valid(dir_valid), .busy(busy), .mode(mode)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Bound on total run time.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: run did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sqDist(int c1, int r1, int c2, int r2);
    int dc;
    int dr;
    dc = (c1 > c2) ? c1 - c2 : c2 - c1;
    dr = (r1 > r2) ? r1 - r2 : r2 - r1;
    return dc * dc + dr * dr;
  endfunction

  function automatic logic [15:0] toDelta(int i);
    logic [7:0] a;
    logic [7:0] b;
    if (i < 0) return 16'h0000;
    a = 8'(dcol[i]);
    b = 8'(drow[i]);
    return {a, b};
  endfunction

  function automatic logic [15:0] lfsrNext(logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  // Returns the chosen direction index, or -1 for STOP.
  function automatic int modelDecide(int md, bit rp, int last, int rnd, logic [3:0] c,
                                     logic [15:0] cur, logic [15:0] pac, logic [15:0] corner);
    int cc, cr, tc, tr, rev, best, bestd, d, i;
    bit ok [4];
    bit any;
    cc = int'(cur[15:8]);
    cr = int'(cur[7:0]);
    if (md == 1 && sqDist(cc, cr, int'(pac[15:8]), int'(pac[7:0])) >= NEAR) begin
      tc = int'(pac[15:8]);
      tr = int'(pac[7:0]);
    end else begin
      tc = int'(corner[15:8]);
      tr = int'(corner[7:0]);
    end
    rev = (last + 2) % 4;
    any = 0;
    for (int k = 0; k < 4; k++) begin
      ok[k] = c[k] && (k != rev);
      any |= ok[k];
    end
    if (!any) ok[rev] = c[rev];
    if (rp && c[rev]) return rev;
    if (md == 2) begin
      for (int k = 0; k < 4; k++) begin
        i = (rnd + k) % 4;
        if (ok[i]) return i;
      end
      return -1;
    end
    best = -1;
    bestd = 0;
    for (int k = 0; k < 4; k++) begin
      if (ok[k]) begin
        d = sqDist((cc + dcol[k]) & 255, (cr + drow[k]) & 255, tc, tr);
        if (best < 0 || d < bestd) begin
          best = k;
          bestd = d;
        end
      end
    end
    return best;
  endfunction

  task automatic modelReset();
    m_mode = 0; m_timer = 0; m_saved_mode = 0; m_saved_timer = 0;
    m_fleft = 0; m_last = 1; m_pend = -1; m_rp = 0; m_busy = 0;
    m_pend_rp = 0; m_dv = 0; m_lfsr = SEED; m_dir_out = 16'h0000;
  endtask

  // Advances the model by one clock edge using the inputs about to be sampled.
  task automatic modelEdge();
    bit clr_rp;
    bit set_rp;
    clr_rp = 0;
    set_rp = 0;
    m_dv = 0;
    if (m_busy) begin
      m_busy = 0;
      m_dv = 1;
      m_dir_out = toDelta(m_pend);
      if (m_pend >= 0) m_last = m_pend;
      clr_rp = m_pend_rp;
    end else if (step) begin
      m_pend = modelDecide(m_mode, m_rp, m_last, int'(m_lfsr[1:0]), clr, cur_loc, pac_loc, corner_loc);
      m_pend_rp = m_rp;
      m_busy = 1;
    end
    if (fright_start) begin
      if (m_mode != 2) begin
        m_saved_mode = m_mode;
        m_saved_timer = m_timer;
        m_mode = 2;
        set_rp = 1;
      end
      m_fleft = FRIG;
    end else if (tick_en) begin
      if (m_mode == 2) begin
        m_fleft--;
        if (m_fleft == 0) begin
          m_mode = m_saved_mode;
          m_timer = m_saved_timer;
        end
      end else begin
        m_timer++;
        if (m_timer == ((m_mode == 0) ? SCAT : CHAS)) begin
          m_mode = 1 - m_mode;
          m_timer = 0;
          set_rp = 1;
        end
      end
    end
    if (set_rp) m_rp = 1;
    else if (clr_rp) m_rp = 0;
    m_lfsr = lfsrNext(m_lfsr);
  endtask

  // One clock: drive controls, advance the model, sample 1 ns after the edge.
  task automatic applyStimulus(input bit t, input bit s, input bit f);
    tick_en = t;
    step = s;
    fright_start = f;
    modelEdge();
    @(posedge clock);
    #1;
    checkOutput("dir_valid", dir_valid, m_dv);
    checkOutput("busy", busy, m_busy);
    checkOutput("mode", mode, m_mode);
    checkOutput("direction", direction, m_dir_out);
  endtask

  task automatic doStep(input string tag, input logic [3:0] c, input logic [15:0] exp);
    clr = c;
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    checkOutput({tag, "_valid"}, dir_valid, 1);
    checkOutput(tag, direction, exp);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0);
  endtask

  initial begin
    int dvCount;
    clock = 0;
    reset = 1;
    tick_en = 0; step = 0; fright_start = 0;
    cur_loc = 16'h0A0A; pac_loc = 16'h0A04; corner_loc = 16'h0A04; clr = 4'hF;
    #1;
    checkOutput("rst_direction", direction, 16'h0000);
    checkOutput("rst_dir_valid", dir_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mode", mode, 0);
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    reset = 0;

    // Schedule flip to CHASE, then the forced reverse of LEFT.
    ticks(SCAT);
    checkOutput("scatter_to_chase", mode, 1);
    doStep("forced_reverse", 4'hF, 16'hFF00);
    doStep("dead_end_left", 4'b0010, 16'h0100);
    doStep("chase_up", 4'hF, 16'h00FF);
    doStep("setup_left", 4'b0010, 16'h0100);
    pac_loc = 16'h0C08; corner_loc = 16'h0C08;
    doStep("tie_up", 4'hF, 16'h00FF);
    pac_loc = 16'h0A14; corner_loc = 16'h0A14;
    doStep("no_reverse_left", 4'hF, 16'h0100);
    doStep("only_up", 4'b0001, 16'h00FF);
    doStep("dead_end_down", 4'b0100, 16'h0001);
    pac_loc = 16'h0B11; corner_loc = 16'h140A;
    doStep("near_pac_corner", 4'hF, 16'h0100);

    // CHASE lasts CHAS ticks.
    ticks(CHAS - 1);
    checkOutput("chase_hold", mode, 1);
    ticks(1);
    checkOutput("chase_to_scatter", mode, 0);

    // FRIGHT entered at CHASE timer 2, extended by a second pulse.
    ticks(SCAT + 2);
    applyStimulus(0, 0, 1);
    checkOutput("fright_enter", mode, 2);
    ticks(2);
    applyStimulus(1, 0, 1);
    ticks(FRIG - 1);
    checkOutput("fright_extended", mode, 2);
    ticks(1);
    checkOutput("fright_restore", mode, 1);
    ticks(CHAS - 3);
    checkOutput("chase_resumed", mode, 1);
    ticks(1);
    checkOutput("resumed_timer", mode, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      clr = 4'($urandom) | 4'($urandom);
      cur_loc = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        pac_loc = {cur_loc[15:8] + 8'($urandom_range(0, 12)) - 8'd6,
                   cur_loc[7:0] + 8'($urandom_range(0, 12)) - 8'd6};
      end else begin
        pac_loc = 16'($urandom);
      end
      corner_loc = 16'($urandom);
      applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4, $urandom_range(0, 99) < 3);
    end

    // Step held for two edges gives a single decision.
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    dvCount = 0;
    applyStimulus(0, 1, 0);
    dvCount += int'(dir_valid);
    applyStimulus(0, 1, 0);
    dvCount += int'(dir_valid);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0);
      dvCount += int'(dir_valid);
    end
    checkOutput("b2b_single_valid", dvCount, 1);

    // Reset between stage 1 and stage 2 discards the decision.
    applyStimulus(0, 1, 0);
    step = 0;
    #3;
    reset = 1;
    #1;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_direction", direction, 16'h0000);
    checkOutput("mid_rst_mode", mode, 0);
    modelReset();
    @(posedge clock);
    #1;
    checkOutput("mid_rst_no_valid", dir_valid, 0);
    reset = 0;
    for (int n = 0; n < 40; n++) begin
      clr = 4'($urandom);
      cur_loc = 16'($urandom);
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
